// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl: drives a bank of WIDTH JK flops as a checked mod-MOD
// up/down/loadable counter, verifying each transition against q_fb.
//
// Ports:
//   clk, reset          rising-edge clock; async active-high reset
//   cmd_valid/cmd_ready command handshake; cmd, cmd_data (LOAD value)
//   halt                ends a RUN, sampled in SETTLE
//   q_fb                q outputs read back from the JK bank
//   j, k                registered per-bit excitation to the bank
//   busy, tc, err       not idle / verified wrap pulse / sticky error
//
// Build option: JK_TOGGLE_EN selects toggle (j=k=1) excitation for changed
// bits instead of set/reset excitation.

module jk_excite_ctrl #(
  parameter int WIDTH = 4,
  parameter int MOD   = 2**WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             halt,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MOD);

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_CLEAR = 3'd1;
  localparam logic [2:0] C_LOAD  = 3'd2;
  localparam logic [2:0] C_SUP   = 3'd3;
  localparam logic [2:0] C_SDN   = 3'd4;
  localparam logic [2:0] C_RUP   = 3'd5;
  localparam logic [2:0] C_RDN   = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic             run;
  logic             dir_up;
  logic             wrap;

  logic             accept;
  logic             q_bad;
  logic             ld_bad;
  logic             go_up;
  logic [WIDTH-1:0] nxt_t;
  logic             nxt_w;

  // Returns {j, k} that move q to t in one edge.
  function automatic logic [2*WIDTH-1:0] excite(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] t
  );
`ifdef JK_TOGGLE_EN
    return {q ^ t, q ^ t};
`else
    return {~q & t, q & ~t};
`endif
  endfunction

  assign cmd_ready = (state == IDLE) & ~reset;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign q_bad     = {1'b0, q_fb} >= MODV;
  assign ld_bad    = {1'b0, cmd_data} >= MODV;

  // Next count from the bank value; direction comes from the new command
  // when idle, otherwise from the running command.
  always_comb begin
    go_up = dir_up;
    if (state == IDLE)
      go_up = (cmd == C_SUP) || (cmd == C_RUP);
    nxt_t = '0;
    nxt_w = 1'b0;
    if (!q_bad) begin
      if (go_up) begin
        nxt_w = (q_fb == MAXV);
        nxt_t = nxt_w ? '0 : q_fb + WIDTH'(1);
      end else begin
        nxt_w = (q_fb == '0);
        nxt_t = nxt_w ? MAXV : q_fb - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      j      <= '0;
      k      <= '0;
      tc     <= 1'b0;
      err    <= 1'b0;
      target <= '0;
      run    <= 1'b0;
      dir_up <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      tc <= 1'b0;
      unique case (state)
        IDLE: begin
          j <= '0;
          k <= '0;
          if (accept) begin
            unique case (cmd)
              C_NOP: ;
              C_CLEAR: begin
                err    <= 1'b0;
                target <= '0;
                {j, k} <= excite(q_fb, '0);
                run    <= 1'b0;
                wrap   <= 1'b0;
                state  <= DRIVE;
              end
              C_LOAD: begin
                if (ld_bad) begin
                  err <= 1'b1;
                end else begin
                  target <= cmd_data;
                  {j, k} <= excite(q_fb, cmd_data);
                  run    <= 1'b0;
                  wrap   <= 1'b0;
                  state  <= DRIVE;
                end
              end
              C_SUP, C_SDN, C_RUP, C_RDN: begin
                if (q_bad)
                  err <= 1'b1;
                target <= nxt_t;
                {j, k} <= excite(q_fb, nxt_t);
                run    <= (cmd == C_RUP) || (cmd == C_RDN);
                dir_up <= go_up;
                wrap   <= nxt_w;
                state  <= DRIVE;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        DRIVE: begin
          j     <= '0;
          k     <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (q_fb != target) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tc <= wrap;
            if (run && !halt) begin
              target <= nxt_t;
              {j, k} <= excite(q_fb, nxt_t);
              wrap   <= nxt_w;
              state  <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// tb_jk_excite_ctrl: drives jk_excite_ctrl against a behavioural JK bank
// and scores each verified count from a queue of expected values.

module tb_jk_excite_ctrl;

  localparam int W = 4;
  localparam int M = 10;

  localparam logic [2:0] C_CLEAR = 3'd1;
  localparam logic [2:0] C_LOAD  = 3'd2;
  localparam logic [2:0] C_SUP   = 3'd3;
  localparam logic [2:0] C_SDN   = 3'd4;
  localparam logic [2:0] C_RUP   = 3'd5;
  localparam logic [2:0] C_RDN   = 3'd6;
  localparam logic [2:0] C_RSVD  = 3'd7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         halt = 1'b0;
  logic [2:0]   cmd = '0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] q_fb, j, k;
  logic         cmd_ready, busy, tc, err;

  logic [W-1:0] bq;
  logic [W-1:0] stk_m = '0;
  logic [W-1:0] stk_v = '0;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         bad;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           nchk = 0;
  int           nerr = 0;
  int           bcnt = 0;
  int           settles = 0;
  logic         tc_pend = 1'b0;
  logic         tc_exp = 1'b0;
  logic [W-1:0] dj = '0;
  logic [W-1:0] dk = '0;

  always #5 clk = ~clk;

  jk_excite_ctrl #(.WIDTH(W), .MOD(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_data  (cmd_data),
    .halt      (halt),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .tc        (tc),
    .err       (err)
  );

  // JK bank: Q+ = J~Q + ~KQ, with optional stuck bits on readback.
  always_ff @(posedge clk or posedge reset)
    if (reset) bq <= '0;
    else       bq <= (j & ~bq) | (~k & bq);

  assign q_fb = (bq & ~stk_m) | (stk_v & stk_m);

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: even busy cycles are SETTLE, odd ones DRIVE.
  always @(negedge clk) begin
    if (reset) begin
      bcnt    = 0;
      tc_pend = 1'b0;
    end else begin
      if (tc_pend) begin
        check("tc", 32'(tc), 32'(tc_exp));
        tc_pend = 1'b0;
      end else if (tc) begin
        check("tc_spurious", 32'(tc), 0);
      end
      if (busy) begin
        bcnt++;
        if (bcnt % 2 == 0) begin
          settles++;
          check("jk_settle", 32'({j, k}), 0);
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            if (!e.bad) check("q_fb", 32'(q_fb), 32'(e.q));
            tc_pend = 1'b1;
            tc_exp  = e.bad ? 1'b0 : e.tc;
          end
        end else begin
          dj = j;
          dk = k;
`ifndef JK_TOGGLE_EN
          check("jk_excl", 32'(j & k), 0);
`endif
        end
      end else begin
        bcnt = 0;
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [W-1:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = '0;
    cmd_data  = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (busy) check("idle_timeout", 0, 1);
  endtask

  task automatic step(input logic [2:0] c, input logic [W-1:0] d,
                      input logic [W-1:0] q, input logic t);
    int n;
    sb.push_back({q, t, 1'b0});
    send(c, d);
    wait_idle(n);
    check("busy_len", n, 2);
  endtask

  initial begin
    int n;
    int b;
    int base;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_jk", 32'({j, k}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_tc", 32'(tc), 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 1);
    check("q_after_rst", 32'(q_fb), 0);

    step(C_SUP, 0, 4'd1, 1'b0);
    step(C_SUP, 0, 4'd2, 1'b0);
    step(C_SUP, 0, 4'd3, 1'b0);
    check("err_steps", 32'(err), 0);

    step(C_LOAD, 4'd5, 4'd5, 1'b0);
    step(C_SUP, 0, 4'd6, 1'b0);
`ifdef JK_TOGGLE_EN
    check("j_5to6", 32'(dj), 32'(4'b0011));
    check("k_5to6", 32'(dk), 32'(4'b0011));
`else
    check("j_5to6", 32'(dj), 32'(4'b0010));
    check("k_5to6", 32'(dk), 32'(4'b0001));
`endif

    step(C_LOAD, 4'd9, 4'd9, 1'b0);
    step(C_SUP, 0, 4'd0, 1'b1);
    check("err_wrap", 32'(err), 0);

    send(C_LOAD, 4'd12);
    b = 0;
    repeat (4) begin
      @(negedge clk);
      b = b | 32'(busy);
    end
    check("ldbad_busy", b, 0);
    check("ldbad_err", 32'(err), 1);
    check("ldbad_q", 32'(q_fb), 0);

    step(C_CLEAR, 0, 4'd0, 1'b0);
    check("clear_err", 32'(err), 0);

    send(C_RSVD, 0);
    @(negedge clk);
    check("rsvd_err", 32'(err), 1);
    check("rsvd_busy", 32'(busy), 0);
    step(C_CLEAR, 0, 4'd0, 1'b0);
    check("clear_err2", 32'(err), 0);

    sb.push_back({4'd9, 1'b1, 1'b0});
    sb.push_back({4'd8, 1'b0, 1'b0});
    sb.push_back({4'd7, 1'b0, 1'b0});
    sb.push_back({4'd6, 1'b0, 1'b0});
    base = settles;
    send(C_RDN, 0);
    for (int i = 0; i < 100 && settles - base < 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("run_progress", settles - base, 3);
    @(negedge clk);
    halt = 1'b1;
    wait_idle(n);
    halt = 1'b0;
    check("run_sb_empty", sb.size(), 0);
    check("run_q", 32'(q_fb), 6);
    check("run_err", 32'(err), 0);

    stk_m = 4'b0001;
    stk_v = 4'b0000;
    sb.push_back({4'd7, 1'b0, 1'b1});
    send(C_RUP, 0);
    wait_idle(n);
    check("stuck_len", n, 2);
    check("stuck_err", 32'(err), 1);
    check("stuck_sb", sb.size(), 0);
    stk_m = '0;
    step(C_CLEAR, 0, 4'd0, 1'b0);
    check("stuck_clr_err", 32'(err), 0);
    check("stuck_clr_q", 32'(q_fb), 0);

    step(C_SDN, 0, 4'd9, 1'b1);

    send(C_RUP, 0);
`ifdef JK_TOGGLE_EN
    check("rst_drive_jk", 32'({j, k}), 32'({4'b1001, 4'b1001}));
`else
    check("rst_drive_jk", 32'({j, k}), 32'({4'b0000, 4'b1001}));
`endif
    reset = 1'b1;
    #1;
    check("abort_jk", 32'({j, k}), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    sb.delete();
    reset = 1'b0;
    #1;
    check("abort_ready_rel", 32'(cmd_ready), 1);
    check("abort_q", 32'(q_fb), 0);
    check("abort_err", 32'(err), 0);

    step(C_SUP, 0, 4'd1, 1'b0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
